c_src_buf_pp: RTL
=================

# c_src_buf_pp

Parametrised, double-buffered (ping-pong) multi-port source buffer for the convolution layer datapath. A write-side stream loader fills one bank with a frame of feature-map words while NUM_P parallel read ports fetch independent addresses from the other, completed bank. Every write is replicated into all NUM_P read copies. The block sits between the input-frame loader and the per-channel convolution engines.

## Interface
Parameters:
- NUM_P, 5: number of parallel read ports (RAM copies per bank)
- DATA_W, 16: word width
- DEPTH, 6144: words per bank
- ADDR_W, 13: address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word can be accepted
- wr_data  in  DATA_W  write word
- wr_last  in  1  last word of frame; qualified by wr_valid & wr_ready
- rd_bank_valid  out  1  read-side bank holds a complete frame
- rd_frame_len  out  ADDR_W+1  word count of the read-side bank's frame
- rd_en  in  1  issue one read on all ports
- rd_addr  in  NUM_P*ADDR_W  port p address in bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_P*DATA_W  port p data in bits [p*DATA_W +: DATA_W]
- rd_valid  out  1  rd_data valid
- rd_release  in  1  reader done with current bank
- ovf  out  1  sticky: a frame was truncated at DEPTH words

## Operation
- Storage: 2 banks x NUM_P copies of DEPTH x DATA_W, synchronous-read RAM. An accepted write goes to the same address in all NUM_P copies of wr_bank.
- State: full[1:0], wr_bank, rd_bank, wr_cnt (0..DEPTH-1), len[0..1] (ADDR_W+1 bits each).
- wr_ready = ~rst & ~full[wr_bank] (combinational).
- Accepted write (wr_valid & wr_ready): word stored at wr_cnt; wr_cnt++.
- Frame close occurs on an accepted write with wr_last=1, or on an accepted write at wr_cnt=DEPTH-1 (the forced close also sets ovf). On close: full[wr_bank]<=1, len[wr_bank]<=wr_cnt+1, wr_cnt<=0, wr_bank toggles.
- rd_bank_valid = full[rd_bank]; rd_frame_len = len[rd_bank].
- A read is serviced when rd_en & rd_bank_valid: each port p reads rd_addr[p] from its copy in rd_bank. If rd_addr >= DEPTH, that port returns 0. rd_en with rd_bank_valid=0 is ignored (no rd_valid).
- Release: rd_release & rd_bank_valid clears full[rd_bank] and toggles rd_bank. rd_release while rd_bank_valid=0 is ignored.
- Simultaneous close and release of different banks in one cycle: both take effect. A read and a release in the same cycle: the read uses the old bank and completes normally.
- Addresses beyond len but < DEPTH return stale bank contents (no check).

## Timing
- Reset values: wr_ready=0 (while rst), rd_bank_valid=0, rd_frame_len=0, rd_data=0, rd_valid=0, ovf=0. Internal: full=0, wr_bank=rd_bank=0, wr_cnt=0, len=0. wr_ready=1 on the first cycle after rst deasserts.
- Read latency is 1: rd_en at cycle T gives rd_data/rd_valid registered at T+1. A new read may be issued every cycle. rd_data holds its last value when rd_valid=0.
- A close at edge T: rd_bank_valid (if it is rd_bank) and wr_ready for the next bank update at T+1. Reads of that frame may be issued at T+1 and return at T+2.
- Release at edge T frees the bank: wr_ready rises at T+1 if the writer was stalled on that bank.
- Reset mid-operation: any in-flight read is dropped (rd_valid=0 after the reset edge), and all frames are discarded.

## Test plan
- Reset, then write a 4-word frame 0x11..0x14 with wr_last on word 4 -> rd_bank_valid=1 and rd_frame_len=4 next cycle; rd_en with all ports addr 0..4 (port p = p) -> rd_data ports 0..3 = 0x11..0x14 and port 4 = stale, one cycle later.
- Write frame A (bank 0), then frame B (bank 1), then offer a third frame -> wr_ready=0; rd_release -> wr_ready=1 the next cycle; third frame lands in bank 0 and reads after second release return its data.
- Stream DEPTH+1 words with no wr_last -> frame closes at word DEPTH, ovf=1 sticky, rd_frame_len=DEPTH; word DEPTH+1 is the first word of the next bank.
- Same cycle: wr_last completes bank 1 while rd_release frees bank 0 and rd_en reads bank 0 -> read returns bank-0 data, rd_bank=1, rd_bank_valid stays 1, wr_ready=1.
- rd_en and rd_release with no full bank -> no rd_valid, no state change; rd_addr=DEPTH on port 2 of a valid read -> port 2 returns 0.
- Assert rst with rd_en one cycle earlier and both banks full -> rd_valid=0, rd_bank_valid=0, ovf=0 after the reset edge.

Source files
------------

// File: rtl/c_src_buf_pp_if.sv
// Bus bundle for the ping-pong source buffer: write stream in, frame status,
// and the multi-port read channel.
interface c_src_buf_pp_if #(
   parameter int NUM_P  = 5,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13
);
   logic                      wr_valid;
   logic                      wr_ready;
   logic [DATA_W-1:0]         wr_data;
   logic                      wr_last;
   logic                      rd_bank_valid;
   logic [ADDR_W:0]           rd_frame_len;
   logic                      rd_en;
   logic [NUM_P*ADDR_W-1:0]   rd_addr;
   logic [NUM_P*DATA_W-1:0]   rd_data;
   logic                      rd_valid;
   logic                      rd_release;
   logic                      ovf;

   modport master (
      output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
      input  wr_ready, rd_bank_valid, rd_frame_len, rd_data, rd_valid, ovf
   );

   modport slave (
      input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
      output wr_ready, rd_bank_valid, rd_frame_len, rd_data, rd_valid, ovf
   );
endinterface

// File: rtl/c_src_buf_pp.sv
// Double-buffered frame store: the writer fills one bank while NUM_P read ports
// fetch independent addresses from the other, completed bank.
module c_src_buf_pp #(
   parameter int NUM_P  = 5,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 6144,
   parameter int ADDR_W = 13
) (
   input  logic          clk,
   input  logic          rst,
   c_src_buf_pp_if.slave bus
);

   logic [1:0]        full;
   logic              wr_bank;
   logic              rd_bank;
   logic [ADDR_W-1:0] wr_cnt;
   logic [ADDR_W:0]   len [2];
   logic              ovf_q;
   logic              rd_valid_q;

   logic wr_fire;
   logic at_end;
   logic close_frame;
   logic rd_fire;
   logic rel_fire;

   assign bus.wr_ready      = ~rst & ~full[wr_bank];
   assign bus.rd_bank_valid = full[rd_bank];
   assign bus.rd_frame_len  = len[rd_bank];
   assign bus.rd_valid      = rd_valid_q;
   assign bus.ovf           = ovf_q;

   assign wr_fire     = bus.wr_valid & bus.wr_ready;
   assign at_end      = (wr_cnt == ADDR_W'(DEPTH - 1));
   assign close_frame = wr_fire & (bus.wr_last | at_end);
   assign rd_fire     = bus.rd_en & full[rd_bank];
   assign rel_fire    = bus.rd_release & full[rd_bank];

   // A close and a release never target the same bank: close needs the write
   // bank empty, release needs the read bank full.
   always_ff @(posedge clk) begin
      if (rst) begin
         full       <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_cnt     <= '0;
         len[0]     <= '0;
         len[1]     <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_fire;
         if (wr_fire) begin
            if (close_frame) begin
               full[wr_bank] <= 1'b1;
               len[wr_bank]  <= {1'b0, wr_cnt} + (ADDR_W+1)'(1);
               wr_cnt        <= '0;
               wr_bank       <= ~wr_bank;
               if (!bus.wr_last) begin
                  ovf_q <= 1'b1;
               end
            end else begin
               wr_cnt <= wr_cnt + ADDR_W'(1);
            end
         end
         if (rel_fire) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   for (genvar p = 0; p < NUM_P; p++) begin : g_port
      logic [DATA_W-1:0] mem [2][DEPTH];
      logic [ADDR_W-1:0] addr;
      logic              in_range;
      logic [DATA_W-1:0] rd_q;

      assign addr     = bus.rd_addr[p*ADDR_W +: ADDR_W];
      assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

      // Every port keeps its own full copy so all ports can read in parallel.
      always_ff @(posedge clk) begin
         if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= bus.wr_data;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_q <= '0;
         end else if (rd_fire) begin
            rd_q <= in_range ? mem[rd_bank][addr] : '0;
         end
      end

      assign bus.rd_data[p*DATA_W +: DATA_W] = rd_q;
   end

endmodule
